// File: rtl/multicycle_control_pkg.sv
// types: opcodes, control FSM states and datapath select encodings for the multicycle core
package types;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP
  } ctrl_state;
  localparam logic [1:0] ASB_REG    = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  function automatic logic is_legal(input opcode o);
    return o inside {OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW};
  endfunction
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing the shared-memory multicycle MIPS datapath
module multicycle_control
  import types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  opcode      op,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegalOp,
  output ctrl_state  state_o
);
  ctrl_state state, nxt;
  opcode op_q;
  // next state; MEMADR steers on the opcode latched in DECODE, not the live IR field
  always_comb begin
    nxt = state;
    case (state)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                    (op == OP_RTYPE) ? EXEC :
                    (op == OP_BEQ) ? BRANCH :
                    (op == OP_J) ? JUMP : FETCH;
      MEMADR: nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      EXEC:   nxt = ALUWB;
      default: nxt = FETCH;
    endcase
  end
  // datapath controls from the registered state; all forced low while in reset
  always_comb begin
    pcWrite = 1'b0;
    pcWriteCond = 1'b0;
    iorD = 1'b0;
    memRead = 1'b0;
    memWrite = 1'b0;
    irWrite = 1'b0;
    memToReg = 1'b0;
    regDst = 1'b0;
    regWrite = 1'b0;
    aluSrcA = 1'b0;
    aluSrcB = ASB_REG;
    aluOp = ALU_ADD;
    pcSource = PCS_ALU;
    illegalOp = 1'b0;
    state_o = rst ? FETCH : state;
    if (!rst) begin
      case (state)
        FETCH: begin
          memRead = 1'b1;
          aluSrcB = ASB_FOUR;
          irWrite = mem_ready;
          pcWrite = mem_ready;
        end
        DECODE: begin
          aluSrcB = ASB_IMM_SH;
          illegalOp = !is_legal(op);
        end
        MEMADR: begin
          aluSrcA = 1'b1;
          aluSrcB = ASB_IMM;
        end
        MEMRD: begin
          memRead = 1'b1;
          iorD = 1'b1;
        end
        MEMWB: begin
          regWrite = 1'b1;
          memToReg = 1'b1;
        end
        MEMWR: begin
          memWrite = 1'b1;
          iorD = 1'b1;
        end
        EXEC: begin
          aluSrcA = 1'b1;
          aluOp = ALU_FUNCT;
        end
        ALUWB: begin
          regWrite = 1'b1;
          regDst = 1'b1;
        end
        BRANCH: begin
          aluSrcA = 1'b1;
          aluOp = ALU_SUB;
          pcWriteCond = 1'b1;
          pcSource = PCS_ALUOUT;
        end
        JUMP: begin
          pcWrite = 1'b1;
          pcSource = PCS_JUMP;
        end
        default: ;
      endcase
    end
  end
  // state register and opcode capture at DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      op_q <= OP_RTYPE;
    end else begin
      state <= nxt;
      if (state == DECODE) op_q <= op;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of state sequence and control outputs per instruction class
module tb_multicycle_control;
  import types::*;
  logic clk = 1'b0;
  logic rst, mem_ready;
  opcode op;
  logic pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSource;
  ctrl_state state_o;
  logic [16:0] ctl;
  int checks = 0;
  int errors = 0;
  // bit order: pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDst regWrite aluSrcA aluSrcB aluOp pcSource illegalOp
  localparam logic [16:0] ZERO    = 17'b0;
  localparam logic [16:0] F_RDY   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] F_WAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] DEC     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] MADR    = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] MRD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] MWB     = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] MWR     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] EXE     = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] AWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] BR      = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] JMP     = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .illegalOp(illegalOp), .state_o(state_o)
  );
  assign ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst,
                regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input ctrl_state st, input logic [16:0] c);
    #0;
    checks++;
    assert (state_o === st) else begin
      errors++;
      $error("FAIL %s state got %0d want %0d", tag, state_o, st);
    end
    checks++;
    assert (ctl === c) else begin
      errors++;
      $error("FAIL %s ctl got %b want %b", tag, ctl, c);
    end
  endtask
  task automatic step(input string tag, input ctrl_state st, input logic [16:0] c);
    @(posedge clk);
    #1;
    chk(tag, st, c);
  endtask
  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    op = OP_LW;
    step("reset", FETCH, ZERO);
    rst = 1'b0;
    #1 chk("lw_fetch", FETCH, F_RDY);
    step("lw_decode", DECODE, DEC);
    step("lw_memadr", MEMADR, MADR);
    op = OP_BEQ;
    step("lw_memrd", MEMRD, MRD);
    step("lw_memwb", MEMWB, MWB);
    step("lw_done", FETCH, F_RDY);
    op = OP_SW;
    step("sw_decode", DECODE, DEC);
    step("sw_memadr", MEMADR, MADR);
    step("sw_memwr1", MEMWR, MWR);
    mem_ready = 1'b0;
    step("sw_memwr2", MEMWR, MWR);
    step("sw_memwr3", MEMWR, MWR);
    mem_ready = 1'b1;
    step("sw_done", FETCH, F_RDY);
    op = OP_BEQ;
    step("beq_decode", DECODE, DEC);
    step("beq_branch", BRANCH, BR);
    step("beq_done", FETCH, F_RDY);
    op = OP_J;
    step("j_decode", DECODE, DEC);
    step("j_jump", JUMP, JMP);
    step("j_done", FETCH, F_RDY);
    op = OP_RTYPE;
    step("r_decode", DECODE, DEC);
    step("r_exec", EXEC, EXE);
    step("r_aluwb", ALUWB, AWB);
    step("r_done", FETCH, F_RDY);
    mem_ready = 1'b0;
    #1 chk("stall1", FETCH, F_WAIT);
    step("stall2", FETCH, F_WAIT);
    step("stall3", FETCH, F_WAIT);
    mem_ready = 1'b1;
    #1 chk("stall_rel", FETCH, F_RDY);
    op = OP_LW;
    step("stall_decode", DECODE, DEC);
    mem_ready = 1'b0;
    step("ign_ready_memadr", MEMADR, MADR);
    step("rst_memrd1", MEMRD, MRD);
    step("rst_memrd2", MEMRD, MRD);
    rst = 1'b1;
    #1 chk("rst_held", FETCH, ZERO);
    step("rst_edge", FETCH, ZERO);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1 chk("post_rst_fetch", FETCH, F_RDY);
    op = opcode'(6'b111111);
    step("ill_decode", DECODE, DEC_ILL);
    step("ill_done", FETCH, F_RDY);
    op = OP_J;
    step("post_ill_decode", DECODE, DEC);
    step("post_ill_jump", JUMP, JMP);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM that sequences the multicycle MIPS datapath: one shared memory for instructions and data, one ALU reused for PC increment, address calculation and execution. It replaces the single-cycle combinational decoder when the core is built in multicycle form. The FSM reads the instruction opcode from the instruction register and drives every datapath mux select and write enable on each cycle. It stalls on a ready handshake from the shared memory.

## Interface
Parameters: none. Opcodes and state encoding come from `types`.

Ports:
- `clk`  in  1  single clock. All state updates happen on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  `opcode`  opcode field of the instruction register. Sampled only in DECODE.
- `mem_ready`  in  1  memory access completes in this cycle.
- `pcWrite`  out  1  unconditional PC write.
- `pcWriteCond`  out  1  PC write gated by ALU zero (beq).
- `iorD`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `memRead`  out  1  memory read request.
- `memWrite`  out  1  memory write request.
- `irWrite`  out  1  instruction register load.
- `memToReg`  out  1  register-file write data: 0 = ALUOut, 1 = MDR.
- `regDst`  out  1  destination register: 0 = rt, 1 = rd.
- `regWrite`  out  1  register-file write.
- `aluSrcA`  out  1  ALU A input: 0 = PC, 1 = register A.
- `aluSrcB`  out  2  ALU B input: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `aluOp`  out  2  00 = add, 01 = sub, 10 = decode from funct.
- `pcSource`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegalOp`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `state_o`  out  `ctrl_state`  current state, for debug and verification.

## Operation
- States and the outputs asserted in each. Every output not listed is driven 0; outputs never carry x.
  - FETCH: `memRead`, `aluSrcB`=01, `aluOp`=00, `pcSource`=00. `irWrite` and `pcWrite` are asserted only in the cycle where `mem_ready`=1.
  - DECODE: `aluSrcB`=11, `aluOp`=00. This precomputes the branch target into ALUOut.
  - MEMADR: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00.
  - MEMRD: `memRead`, `iorD`.
  - MEMWB: `regWrite`, `memToReg`, `regDst`=0.
  - MEMWR: `memWrite`, `iorD`.
  - EXEC: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10.
  - ALUWB: `regWrite`, `regDst`=1, `memToReg`=0.
  - BRANCH: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=01, `pcWriteCond`, `pcSource`=01.
  - JUMP: `pcWrite`, `pcSource`=10.
- Transitions:
  - FETCH → DECODE when `mem_ready`=1; otherwise stay in FETCH.
  - DECODE → one of:
    - MEMADR for OP_LW or OP_SW.
    - EXEC for OP_RTYPE.
    - BRANCH for OP_BEQ.
    - JUMP for OP_J.
    - FETCH for any other opcode, with `illegalOp`=1 for that cycle.
  - MEMADR → MEMRD for OP_LW, MEMWR for OP_SW.
  - MEMRD → MEMWB when `mem_ready`=1; otherwise stay.
  - MEMWR → FETCH when `mem_ready`=1; otherwise stay.
  - EXEC → ALUWB.
  - MEMWB, ALUWB, BRANCH and JUMP → FETCH.
- In MEMADR the FSM reuses the opcode captured at DECODE, held in an internal register `op_q`. It does not re-read `op`.
- During a wait, `memRead`/`memWrite` and `iorD` are held stable for every cycle of that state.

## Timing
- Reset: `rst`=1 at a rising edge sets state to FETCH and clears `op_q`.
  - While `rst` is high, all outputs are forced to 0 and `state_o`=FETCH.
  - Reset in any state, including mid-wait, aborts the instruction. No write enable is asserted in the reset cycle.
- Outputs are decoded from the registered state, plus `mem_ready` for the FETCH write enables. There is no combinational path from `op` to any output except `illegalOp` in DECODE.
- Cycles per instruction with zero-wait memory (`mem_ready` always 1):
  - lw: 5
  - sw: 4
  - R-type: 4
  - beq: 3
  - j: 3
  - illegal: 2
- Each cycle that `mem_ready` is held low adds one cycle in FETCH, MEMRD or MEMWR.
- `mem_ready` is ignored in every state that does not access memory.

## Structure
- The `types` package gains:
  - `OP_J` = 6'b000010, added to `opcode`.
  - `ctrl_state` enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP.
  - Localparams for the `aluSrcB` and `pcSource` encodings.
- Single module with no submodules. Organise it as a next-state `always_comb`, an output `always_comb`, and an `always_ff` for the state and `op_q` registers.

## Test plan
- lw, `mem_ready`=1 throughout: after reset release the state sequence is FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `regWrite`=1 and `memToReg`=1 in cycle 5 only.
- sw with `mem_ready` low for 2 cycles in MEMWR: MEMWR is held 3 cycles with `memWrite`=1 and `iorD`=1 in all 3, then FETCH. `regWrite` stays 0 throughout.
- beq, then j: BRANCH asserts `pcWriteCond`=1, `aluOp`=01, `pcSource`=01. JUMP asserts `pcWrite`=1, `pcSource`=10. Each returns to FETCH on the third cycle.
- Fetch stall: `mem_ready`=0 for 3 cycles in FETCH means `irWrite`=`pcWrite`=0 for those cycles, then both are 1 for exactly one cycle.
- Illegal opcode 6'b111111: `illegalOp` pulses 1 in DECODE, the next state is FETCH, and no write enable is asserted.
- `rst` asserted in MEMRD during a wait: the next state is FETCH and all outputs are 0 during reset. After release the FSM fetches normally.
